// File: rtl/vedic_mul_arbiter.sv
// Two-requester front end sharing one 4x4 Vedic multiplier.
// Round-robin grant, fixed three-cycle IDLE/MUL/RESP sequence, and a response held under backpressure.
module vedic_mul_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_p,
    output logic       busy,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_q;
    logic       last_grant_q;
    logic [3:0] op_a_q;
    logic [3:0] op_b_q;
    logic       op_id_q;
    logic       rsp_valid_q;
    logic       rsp_id_q;
    logic [7:0] rsp_p_q;
    logic [7:0] op_count_q;

    logic       grant_id;
    logic       accept;
    logic [7:0] product;

    // 2x2 Urdhva-Tiryagbhyam cell: vertical and crosswise partial products.
    function automatic logic [3:0] vedic2(input logic [1:0] a, input logic [1:0] b);
        logic c1, c2, t, carry;
        c1    = a[1] & b[0];
        c2    = a[0] & b[1];
        carry = c1 & c2;
        t     = a[1] & b[1];
        return {t & carry, t ^ carry, c1 ^ c2, a[0] & b[0]};
    endfunction

    function automatic logic [7:0] vedic4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] q0, q1, q2, q3;
        q0 = vedic2(a[1:0], b[1:0]);
        q1 = vedic2(a[3:2], b[1:0]);
        q2 = vedic2(a[1:0], b[3:2]);
        q3 = vedic2(a[3:2], b[3:2]);
        return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
    endfunction

    assign product = vedic4(op_a_q, op_b_q);

    always_comb begin
        // NOTE: default assignment first so every path drives grant_id; no latch is inferred.
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Readys are combinational from valids; rst gates them so nothing is offered during reset.
    assign accept     = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_a_q       <= 4'd0;
            op_b_q       <= 4'd0;
            op_id_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_p_q      <= 8'd0;
            op_count_q   <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments keep every register update order-independent.
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_a_q       <= grant_id ? req1_a : req0_a;
                        op_b_q       <= grant_id ? req1_b : req0_b;
                        op_id_q      <= grant_id;
                        last_grant_q <= grant_id;
                        state_q      <= MUL;
                    end
                end
                MUL: begin
                    rsp_p_q     <= product;
                    rsp_id_q    <= op_id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + 8'd1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_p     = rsp_p_q;
    assign op_count  = op_count_q;
    assign busy      = (state_q != IDLE);

endmodule
